// File: rtl/cvx_addx_responder.sv
// -----------------------------------------------------------------------------
// cvx_addx_responder
//
// Purpose:
//   Coprocessor responder for two custom R-type instructions on the custom-0
//   opcode: ADDX (rd = rs1 + rs2) and SUBX (rd = rs1 - rs2). It decodes issue
//   requests combinationally and computes the result on issue. Each result is
//   parked in a 2-entry buffer until the core commits or kills it. Committed
//   results are then returned oldest-first over a valid/ready result channel.
//
// Ports:
//   clk_i              rising-edge clock
//   rst_ni             asynchronous active-low reset
//   issue_valid_i      issue request from the core
//   issue_ready_o      a buffer entry is free (registered state only)
//   issue_instr_i      32-bit instruction word
//   issue_id_i         instruction ID
//   issue_rs1_i/rs2_i  source operands
//   issue_accept_o     combinational decode result
//   issue_writeback_o  accepted instruction writes rd (equals accept)
//   commit_valid_i     commit/kill decision present
//   commit_id_i        ID the decision applies to
//   commit_kill_i      1 = discard, 0 = release result
//   result_valid_o     a committed result is presented
//   result_ready_i     core takes the result
//   result_id_o        ID of the presented result
//   result_rd_o        destination register
//   result_data_o      result value (driven even when rd is x0)
//   result_we_o        rd != 0
// -----------------------------------------------------------------------------
module cvx_addx_responder #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned IdWidth = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [4:0]         result_rd_o,
    output logic [XLEN-1:0]    result_data_o,
    output logic               result_we_o
);

    localparam int NumEntries = 2;

    typedef enum logic [1:0] {
        ST_EMPTY       = 2'd0,
        ST_WAIT_COMMIT = 2'd1,
        ST_READY       = 2'd2
    } entry_state_e;

    // Buffer entries. r_age[i]=1 marks entry i as the older of two live entries.
    entry_state_e       r_state [NumEntries];
    logic [IdWidth-1:0] r_id    [NumEntries];
    logic [4:0]         r_rd    [NumEntries];
    logic [XLEN-1:0]    r_data  [NumEntries];
    logic [NumEntries-1:0] r_age;

    // Entry presented but not taken last cycle; keeps the payload pinned to it
    // even if an older entry becomes READY meanwhile.
    logic r_hold_valid;
    logic r_hold_idx;

    // ---------------------------------------------------------------- decode
    logic            w_opcode_ok;
    logic            w_funct3_ok;
    logic            w_is_add;
    logic            w_is_sub;
    logic            w_accept;
    logic [XLEN-1:0] w_result;
    logic            w_issue_fire;
    logic            w_same_commit;
    logic            w_unused_fields;

    assign w_opcode_ok = (issue_instr_i[6:0] == 7'b0001011);
    assign w_funct3_ok = (issue_instr_i[14:12] == 3'b000);
    assign w_is_add    = (issue_instr_i[31:25] == 7'b0000000);
    assign w_is_sub    = (issue_instr_i[31:25] == 7'b0000001);
    assign w_accept    = w_opcode_ok & w_funct3_ok & (w_is_add | w_is_sub);

    // Register-specifier fields are not needed: operands arrive by value.
    assign w_unused_fields = ^issue_instr_i[24:15];

    // Width-limited arithmetic: carry/borrow falls off the top.
    assign w_result = w_is_sub ? (issue_rs1_i - issue_rs2_i)
                               : (issue_rs1_i + issue_rs2_i);

    assign issue_accept_o    = issue_valid_i & w_accept;
    assign issue_writeback_o = issue_valid_i & w_accept;

    // -------------------------------------------------------- per-entry flags
    logic [NumEntries-1:0] w_empty;
    logic [NumEntries-1:0] w_ready;
    logic [NumEntries-1:0] w_commit_hit;
    logic [NumEntries-1:0] w_alloc;
    logic [NumEntries-1:0] w_pop;
    logic [NumEntries-1:0] w_free;
    logic                  w_alloc_idx;
    logic                  w_sel_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NumEntries; gi++) begin : g_entry_flags
            assign w_empty[gi]      = (r_state[gi] == ST_EMPTY);
            assign w_ready[gi]      = (r_state[gi] == ST_READY);
            assign w_commit_hit[gi] = commit_valid_i
                                    & (r_state[gi] == ST_WAIT_COMMIT)
                                    & (r_id[gi] == commit_id_i);
            assign w_alloc[gi]      = w_issue_fire & (w_alloc_idx == 1'(gi));
            assign w_pop[gi]        = result_valid_o & result_ready_i
                                    & (w_sel_idx == 1'(gi));
            assign w_free[gi]       = (w_commit_hit[gi] & commit_kill_i) | w_pop[gi];
        end
    endgenerate

    // Readiness comes from registered state only, so a slot freed by this
    // cycle's result handshake is offered from the next cycle on.
    assign issue_ready_o = |w_empty;
    assign w_alloc_idx   = w_empty[0] ? 1'b0 : 1'b1;
    assign w_issue_fire  = issue_valid_i & issue_ready_o & w_accept;
    assign w_same_commit = commit_valid_i & (commit_id_i == issue_id_i);

    // Oldest READY entry, unless a stalled presentation must be held.
    always_comb begin
        w_sel_idx = 1'b0;
        if (r_hold_valid) begin
            w_sel_idx = r_hold_idx;
        end else if (&w_ready) begin
            w_sel_idx = r_age[1];
        end else begin
            w_sel_idx = w_ready[1];
        end
    end

    // ---------------------------------------------------------------- result
    assign result_valid_o = |w_ready;
    assign result_id_o    = result_valid_o ? r_id[w_sel_idx]   : '0;
    assign result_rd_o    = result_valid_o ? r_rd[w_sel_idx]   : 5'd0;
    assign result_data_o  = result_valid_o ? r_data[w_sel_idx] : '0;
    assign result_we_o    = result_valid_o & (r_rd[w_sel_idx] != 5'd0);

    // ----------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumEntries; i++) begin
                r_state[i] <= ST_EMPTY;
                r_id[i]    <= '0;
                r_rd[i]    <= 5'd0;
                r_data[i]  <= '0;
            end
            r_age        <= '0;
            r_hold_valid <= 1'b0;
            r_hold_idx   <= 1'b0;
        end else begin
            for (int i = 0; i < NumEntries; i++) begin
                if (w_alloc[i]) begin
                    r_id[i]   <= issue_id_i;
                    r_rd[i]   <= issue_instr_i[11:7];
                    r_data[i] <= w_result;
                    r_age[i]  <= 1'b0;
                    // A commit for the ID being issued right now targets
                    // the new entry directly.
                    if (w_same_commit) begin
                        r_state[i] <= commit_kill_i ? ST_EMPTY : ST_READY;
                    end else begin
                        r_state[i] <= ST_WAIT_COMMIT;
                    end
                end else begin
                    if (w_commit_hit[i]) begin
                        r_state[i] <= commit_kill_i ? ST_EMPTY : ST_READY;
                    end else if (w_pop[i]) begin
                        r_state[i] <= ST_EMPTY;
                    end
                    // A surviving entry becomes the older one when the other
                    // slot is allocated.
                    if (w_free[i]) begin
                        r_age[i] <= 1'b0;
                    end else if (w_issue_fire && !w_empty[i]) begin
                        r_age[i] <= 1'b1;
                    end
                end
            end
            r_hold_valid <= result_valid_o & ~result_ready_i;
            r_hold_idx   <= w_sel_idx;
        end
    end

endmodule
